// File: rtl/wildcat_uart_pkg.sv
// Shared UART definitions for the Wildcat RX/TX blocks: state encoding,
// frame width and the bit-period helper.
package wildcat_uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_IDX_W     = $clog2(UART_DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // Clock cycles per serial bit, truncated.
    function automatic int bit_cycles(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/wildcat_uart_rx_if.sv
// Byte delivery bus from the UART receiver to the core's I/O bus.
interface wildcat_uart_rx_if;
    import wildcat_uart_pkg::*;

    // A byte transfers on any clock edge where rx_valid & rx_ready are both 1;
    // rx_data is held stable while rx_valid is 1; rx_ready is ignored while
    // rx_valid is 0. frame_err and overrun are one-cycle status pulses.
    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_ready;
    logic                      frame_err;
    logic                      overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready
    );

endinterface

// File: rtl/wildcat_sync2.sv
// Two-flop synchronizer for asynchronous pins; the reset value matches the
// pin's idle level so no false edge is seen when reset releases.
module wildcat_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/wildcat_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of the synchronized line, delivering
// bytes through a one-entry valid/ready holding register.
module wildcat_uart_rx
    import wildcat_uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx,
    wildcat_uart_rx_if.master   bus,
    output rx_state_t           o_dbg_state
);

    localparam int BIT_CYCLES  = bit_cycles(CLK_FREQ, BAUD_RATE);
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CW          = $clog2(BIT_CYCLES);

    localparam logic [CW-1:0]         BIT_RELOAD  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0]         HALF_RELOAD = CW'(HALF_CYCLES - 1);
    localparam logic [UART_IDX_W-1:0] LAST_IDX    = UART_IDX_W'(UART_DATA_BITS - 1);

    generate
        if (BIT_CYCLES < 4) begin : g_bad_baud
            $error("wildcat_uart_rx: BIT_CYCLES=%0d is below the minimum of 4", BIT_CYCLES);
        end
    endgenerate

    logic w_rx_s;
    logic w_cnt_zero;
    logic w_hs;

    rx_state_t                 r_state;
    logic [CW-1:0]             r_cnt;
    logic [UART_IDX_W-1:0]     r_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_ferr;
    logic                      r_ovr;

    wildcat_sync2 #(.RST_VAL(1'b1)) u_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (rx),
        .o_q     (w_rx_s)
    );

    assign w_cnt_zero = (r_cnt == '0);
    assign w_hs       = r_valid & bus.rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
            // A delivery in STOP below overrides this clear in the same cycle.
            if (w_hs) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_cnt   <= HALF_RELOAD;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= BIT_RELOAD;
                        r_idx   <= '0;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_shift <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                        r_idx   <= r_idx + UART_IDX_W'(1);
                        r_cnt   <= BIT_RELOAD;
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (w_rx_s) begin
                        // Holding register accepts when empty or draining this cycle.
                        if (!r_valid || bus.rx_ready) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_ovr <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end else begin
                        r_ferr  <= 1'b1;
                        r_state <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rx_data   = r_data;
    assign bus.rx_valid  = r_valid;
    assign bus.frame_err = r_ferr;
    assign bus.overrun   = r_ovr;
    assign o_dbg_state   = r_state;

endmodule
